inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC SHALL be declared: default 32'h0000_2000, the PC loaded on reset.
REQ-002 Port clk SHALL be: input, 1 bit, single clock; all state updates on rising edge.
REQ-003 Port reset SHALL be: input, 1 bit, synchronous and active-high.
REQ-004 Port imem_req SHALL be: output, 1 bit, fetch request valid.
REQ-005 Port imem_addr SHALL be: output, 32 bits, word-aligned fetch address.
REQ-006 Port imem_ready SHALL be: input, 1 bit, memory accepts the request this cycle.
REQ-007 Port imem_resp_valid SHALL be: input, 1 bit, response data valid.
REQ-008 Port imem_resp_data SHALL be: input, 32 bits, fetched instruction word.
REQ-009 Port redirect SHALL be: input, 1 bit, branch/jump taken from a later stage.
REQ-010 Port redirect_pc SHALL be: input, 32 bits, new fetch target.
REQ-011 Port stall SHALL be: input, 1 bit, decode (stage1) cannot accept this cycle.
REQ-012 Port inst SHALL be: output, 32 bits, instruction to decode/ImmGen.
REQ-013 Port inst_pc SHALL be: output, 32 bits, PC of inst.
REQ-014 Port inst_valid SHALL be: output, 1 bit, inst/inst_pc valid.
REQ-015 Port inst_count SHALL be: output, 32 bits, delivered-instruction counter (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT and HOLD, with at most one outstanding memory request.
REQ-017 In IDLE, imem_req SHALL be 0, and the next state SHALL be REQ.
REQ-018 In REQ, imem_req=1 and imem_addr=pc; on imem_ready the next state SHALL be WAIT with req_pc<=pc, otherwise REQ.
REQ-019 In WAIT, when imem_resp_valid && !drop, the next cycle SHALL give inst<=imem_resp_data, inst_pc<=req_pc, inst_valid<=1, pc<=req_pc+4, and state HOLD.
REQ-020 In WAIT, when imem_resp_valid && drop, the response SHALL be discarded, drop cleared, and the next state SHALL be REQ.
REQ-021 In HOLD, a consumed instruction (inst_valid && !stall) SHALL give inst_valid<=0 next cycle and next state REQ; otherwise inst/inst_pc/inst_valid SHALL hold stable.
REQ-022 When inst_valid=0, inst SHALL read 32'h0000_0013 (NOP).
REQ-023 Redirect SHALL take priority over all other events: pc<={redirect_pc[31:2],2'b00}, inst_valid<=0, next state REQ.
REQ-024 A redirect in WAIT without a same-cycle response SHALL set drop=1.
REQ-025 A redirect in WAIT with a same-cycle response SHALL discard that response and leave drop=0.
REQ-026 A redirect in REQ with a same-cycle imem_ready SHALL let the request issue, set drop=1, and go to WAIT.
REQ-027 When redirect and stall are asserted together, redirect SHALL win and the held instruction SHALL be dropped.
REQ-028 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-029 imem_resp_valid outside WAIT SHALL be ignored.
REQ-030 Throughput SHALL be one instruction per 3 cycles minimum, given REQ, WAIT and HOLD with imem_ready and resp_valid each arriving in the first cycle of their state.

Reset
REQ-031 On reset, state SHALL become IDLE, pc<=RESET_PC, req_pc<=RESET_PC, drop<=0, inst_valid<=0, inst=NOP, inst_pc<=RESET_PC, imem_req=0, inst_count<=0.
REQ-032 Reset mid-WAIT SHALL abandon the outstanding request, and its late response SHALL be ignored per REQ-029.

Configuration
REQ-033 With macro FETCH_PERF_EN defined, inst_count SHALL increment by 1, wrapping, each cycle inst_valid && !stall && !redirect.
REQ-034 Without FETCH_PERF_EN, inst_count SHALL be tied to 32'h0, with no counter register.

Verification
REQ-035 Reset, then imem_ready=1 and resp_valid=1 on first WAIT cycle with data 32'h00500093 -> imem_addr=0x2000, inst=0x00500093, inst_pc=0x2000, inst_valid=1; next fetch addr 0x2004.
REQ-036 Stall held 4 cycles in HOLD -> inst and inst_pc stable, no imem_req asserted; stall drops -> next request at inst_pc+4.
REQ-037 Redirect to 0x3002 while in WAIT, then response 0xDEADBEEF -> response discarded; next imem_addr=0x3000; inst_valid never shows 0xDEADBEEF.
REQ-038 Redirect to 0x4000 with simultaneous stall in HOLD -> inst_valid=0 next cycle, imem_addr=0x4000.
REQ-039 RESET_PC=32'hFFFF_FFFC, one fetch completed -> next imem_addr=0x0000_0000.
REQ-040 FETCH_PERF_EN defined, 5 instructions consumed, one stalled 2 cycles -> inst_count=5; undefined -> inst_count=0 throughout.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch stage.
// Fetches one word at a time from instruction memory, holds it for decode,
// and handles redirects by dropping stale responses.
// Optional feature macro: FETCH_PERF_EN (adds the delivered-instruction counter).
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic [31:0] inst_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_req_pc, w_req_pc_next;
    logic        r_drop, w_drop_next;
    logic [31:0] r_inst, w_inst_next;
    logic [31:0] r_inst_pc, w_inst_pc_next;
    logic        r_inst_valid, w_inst_valid_next;
    logic [31:0] w_redirect_target;

    // Redirect targets are forced to word alignment.
    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req   = (r_state == S_REQ);
    assign imem_addr  = r_pc;
    assign inst       = r_inst_valid ? r_inst : NOP;
    assign inst_pc    = r_inst_pc;
    assign inst_valid = r_inst_valid;

    // Next-state logic; redirect overrides every other event.
    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_req_pc_next     = r_req_pc;
        w_drop_next       = r_drop;
        w_inst_next       = r_inst;
        w_inst_pc_next    = r_inst_pc;
        w_inst_valid_next = r_inst_valid;
        if (redirect) begin
            w_pc_next         = w_redirect_target;
            w_inst_valid_next = 1'b0;
            w_state_next      = S_REQ;
            w_drop_next       = 1'b0;
            if (r_state == S_REQ && imem_ready) begin
                // Request still issues this cycle; its response is stale.
                w_req_pc_next = r_pc;
                w_drop_next   = 1'b1;
                w_state_next  = S_WAIT;
            end else if (r_state == S_WAIT && !imem_resp_valid) begin
                // The old request is still in flight: wait for it and throw
                // it away so that at most one request is ever outstanding.
                w_drop_next  = 1'b1;
                w_state_next = S_WAIT;
            end
        end else begin
            case (r_state)
                S_IDLE: w_state_next = S_REQ;
                S_REQ: begin
                    if (imem_ready) begin
                        w_req_pc_next = r_pc;
                        w_state_next  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (r_drop) begin
                            w_drop_next  = 1'b0;
                            w_state_next = S_REQ;
                        end else begin
                            w_inst_next       = imem_resp_data;
                            w_inst_pc_next    = r_req_pc;
                            w_inst_valid_next = 1'b1;
                            w_pc_next         = r_req_pc + 32'd4;
                            w_state_next      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_inst_valid && !stall) begin
                        w_inst_valid_next = 1'b0;
                        w_state_next      = S_REQ;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_req_pc     <= RESET_PC;
            r_drop       <= 1'b0;
            r_inst       <= NOP;
            r_inst_pc    <= RESET_PC;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_req_pc     <= w_req_pc_next;
            r_drop       <= w_drop_next;
            r_inst       <= w_inst_next;
            r_inst_pc    <= w_inst_pc_next;
            r_inst_valid <= w_inst_valid_next;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_inst_count;

    // Count instructions actually handed to decode.
    always_ff @(posedge clk) begin
        if (reset)
            r_inst_count <= 32'h0;
        else if (r_inst_valid && !stall && !redirect)
            r_inst_count <= r_inst_count + 32'd1;
    end

    assign inst_count = r_inst_count;
`else
    assign inst_count = 32'h0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic        imem_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] inst, inst2;
    logic [31:0] inst_pc, inst_pc2;
    logic        inst_valid, inst_valid2;
    logic [31:0] inst_count, inst_count2;

    int passed = 0;
    int total  = 0;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .inst_count(inst_count)
    );

    // Second instance exercises PC wrap; it shares stimulus with dut.
    inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ready(imem_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .inst(inst2), .inst_pc(inst_pc2), .inst_valid(inst_valid2),
        .inst_count(inst_count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One fetch from REQ through to HOLD, with single-cycle ready/response.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, addr);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = data;
        step();
        imem_resp_valid = 1'b0;
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        chk({tag, "_inst"}, inst, data);
        chk({tag, "_pc"}, inst_pc, addr);
    endtask

    initial begin
        reset = 1'b1;
        imem_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        stall = 1'b0;
        step();
        step();
        // Reset state
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_pc", inst_pc, 32'h0000_2000);
        chk("rst_count", inst_count, 32'h0);
        chk("rst_pc_wrap", inst_pc2, 32'hFFFF_FFFC);
        reset = 1'b0;
        step();                                  // IDLE -> REQ
        chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
        // Basic fetch
        fetch("f0", 32'h0000_2000, 32'h0050_0093);
        step();                                  // consumed -> REQ
        chk("f0_next_addr", imem_addr, 32'h0000_2004);
        chk("wrap_next_addr", imem_addr2, 32'h0000_0000);
        chk("f0_nop", inst, 32'h0000_0013);
        chk("cnt1", inst_count, PERF ? 32'd1 : 32'd0);
        // Stall held for 4 cycles in HOLD
        fetch("f1", 32'h0000_2004, 32'h00A0_0113);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_inst", inst, 32'h00A0_0113);
            chk("stall_pc", inst_pc, 32'h0000_2004);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
        end
        stall = 1'b0;
        step();
        chk("unstall_addr", imem_addr, 32'h0000_2008);
        chk("cnt2", inst_count, PERF ? 32'd2 : 32'd0);
        // Redirect while WAIT, stale response later discarded
        imem_ready = 1'b1;
        step();                                  // -> WAIT
        imem_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_3002;
        step();
        redirect = 1'b0;
        chk("rdw_req", {31'd0, imem_req}, 32'd0);
        chk("rdw_valid", {31'd0, inst_valid}, 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hDEAD_BEEF;
        step();
        imem_resp_valid = 1'b0;
        chk("rdw_drop_valid", {31'd0, inst_valid}, 32'd0);
        chk("rdw_drop_inst", inst, 32'h0000_0013);
        // Redirect with stall in HOLD
        fetch("f2", 32'h0000_3000, 32'h1111_1111);
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_4000;
        step();
        stall = 1'b0;
        redirect = 1'b0;
        chk("rds_valid", {31'd0, inst_valid}, 32'd0);
        chk("rds_cnt", inst_count, PERF ? 32'd2 : 32'd0);
        // Three more consumed; the second stalls two cycles
        for (int k = 0; k < 3; k++) begin
            fetch("loop", 32'h0000_4000 + 32'(k * 4), 32'hA000_0000 + 32'(k));
            if (k == 1) begin
                stall = 1'b1;
                step();
                step();
                chk("loop_stall_pc", inst_pc, 32'h0000_4004);
                stall = 1'b0;
            end
            step();
        end
        chk("cnt5", inst_count, PERF ? 32'd5 : 32'd0);
        // Redirect in REQ with same-cycle ready: issue, then drop response
        chk("rdr_addr", imem_addr, 32'h0000_400C);
        redirect = 1'b1;
        redirect_pc = 32'h0000_5000;
        imem_ready = 1'b1;
        step();
        redirect = 1'b0;
        imem_ready = 1'b0;
        chk("rdr_req", {31'd0, imem_req}, 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hBAD0_BAD0;
        step();
        imem_resp_valid = 1'b0;
        chk("rdr_valid", {31'd0, inst_valid}, 32'd0);
        // Redirect in WAIT with same-cycle response: no lingering drop
        imem_ready = 1'b1;
        chk("rdr_addr2", imem_addr, 32'h0000_5000);
        step();
        imem_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_6000;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hBAD1_BAD1;
        step();
        redirect = 1'b0;
        imem_resp_valid = 1'b0;
        chk("rdwr_valid", {31'd0, inst_valid}, 32'd0);
        fetch("f3", 32'h0000_6000, 32'h2222_2222);
        chk("cnt_final", inst_count, PERF ? 32'd5 : 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
